frameblock_ring_controller: RTL

- Parametrised N-buffer successor to the double-buffered frameblock controller.
- Holds NUM_BUF partial-framebuffer banks of 2^ADDR_W pixels each, used in strict round-robin.
- The draw engine fills one bank while the display engine streams out another. Filled banks queue in order, so drawing can run up to NUM_BUF-1 blocks ahead of display.
- Sits between the triangle rasteriser (draw side) and the LCD/SPI pixel pusher (display side).

---
 rtl/frameblock_pkg.sv | 21 ++
 rtl/frameblock_ring_controller_bank.sv | 27 ++
 rtl/frameblock_ring_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/frameblock_pkg.sv
// Shared types and constants for the round-robin frameblock ring controller.
// Optional hardware bank clear is enabled with the FRAMEBLOCK_AUTOCLEAR_EN macro.
package frameblock_pkg;

    typedef enum logic [1:0] {
        BANK_FREE = 2'd0,
        BANK_DRAW = 2'd1,
        BANK_FULL = 2'd2,
        BANK_SHOW = 2'd3
    } bank_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_ID_W   = 7;

    // Bank index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frameblock_ring_controller_bank.sv
// One partial-framebuffer bank: simple dual-port RAM with a registered read.
// Used by frameblock_ring_controller (FRAMEBLOCK_AUTOCLEAR_EN has no effect here).
module frameblock_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wraddr,
    input  logic [DATA_W-1:0] wrdata,
    input  logic [ADDR_W-1:0] rdaddr,
    output logic [DATA_W-1:0] rddata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rddata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wraddr] <= wrdata;
        end
        rddata_q <= mem[rdaddr];
    end

    assign rddata = rddata_q;

endmodule

// File: rtl/frameblock_ring_controller.sv
// NUM_BUF-deep round-robin ring of framebuffer banks between rasteriser and display.
// Define FRAMEBLOCK_AUTOCLEAR_EN to sweep CLEAR_VALUE into each bank before it is drawn.
module frameblock_ring_controller
    import frameblock_pkg::*;
#(
    parameter int                NUM_BUF     = 3,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                ID_W        = DEF_ID_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            draw_wrdata,
    input  logic [ADDR_W-1:0]            draw_wraddr,
    input  logic                         draw_we,
    input  logic [ADDR_W-1:0]            draw_rdaddr,
    output logic [DATA_W-1:0]            draw_rddata,
    input  logic [ID_W-1:0]              draw_id,
    input  logic                         draw_next,
    output logic                         draw_ready,
    input  logic [ADDR_W-1:0]            display_rdaddr,
    output logic [DATA_W-1:0]            display_rddata,
    output logic [ID_W-1:0]              display_id,
    input  logic                         display_next,
    output logic                         display_ready,
    output logic [$clog2(NUM_BUF+1)-1:0] full_count
);

    localparam int IDX_W = idx_width(NUM_BUF);
    localparam int CNT_W = $clog2(NUM_BUF+1);

    bank_state_e       state_q [NUM_BUF];
    bank_state_e       state_d [NUM_BUF];
    logic [ID_W-1:0]   id_q    [NUM_BUF];
    logic [ID_W-1:0]   id_d    [NUM_BUF];
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0]  full_count_q, full_count_d;
    logic [ID_W-1:0]   display_id_q, display_id_d;

    logic              draw_accept, display_accept, write_en;
    logic [ADDR_W-1:0] bank_wraddr;
    logic [DATA_W-1:0] bank_wrdata;
    logic              bank_we     [NUM_BUF];
    logic [ADDR_W-1:0] bank_rdaddr [NUM_BUF];
    logic [DATA_W-1:0] bank_rddata [NUM_BUF];

`ifdef FRAMEBLOCK_AUTOCLEAR_EN
    logic              clear_busy_q, clear_busy_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_BUF-1)) ? '0 : idx + 1'b1;
    endfunction

    assign draw_ready     = (state_q[wr_idx_q] == BANK_DRAW);
    assign display_ready  = (state_q[rd_idx_q] == BANK_SHOW);
    assign draw_accept    = draw_next && draw_ready;
    assign display_accept = display_next && display_ready;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        wr_sel_d     = wr_idx_q;
        rd_sel_d     = rd_idx_q;
        display_id_d = id_q[rd_idx_q];
        full_count_d = full_count_q + CNT_W'(draw_accept) - CNT_W'(display_accept);
`ifdef FRAMEBLOCK_AUTOCLEAR_EN
        clear_busy_d = clear_busy_q;
        clear_addr_d = clear_addr_q;
`endif
        if (draw_accept) begin
            state_d[wr_idx_q] = BANK_FULL;
            id_d[wr_idx_q]    = draw_id;
            wr_idx_d          = next_idx(wr_idx_q);
        end else if (state_q[wr_idx_q] == BANK_FREE) begin
`ifdef FRAMEBLOCK_AUTOCLEAR_EN
            // The bank stays FREE for the whole sweep, so a reset simply abandons it.
            if (!clear_busy_q) begin
                clear_busy_d = 1'b1;
                clear_addr_d = '0;
            end else begin
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == '1) begin
                    clear_busy_d      = 1'b0;
                    state_d[wr_idx_q] = BANK_DRAW;
                end
            end
`else
            state_d[wr_idx_q] = BANK_DRAW;
`endif
        end
        // Draw and display only ever touch banks in disjoint states, so no conflict.
        if (display_accept) begin
            state_d[rd_idx_q] = BANK_FREE;
            rd_idx_d          = next_idx(rd_idx_q);
        end else if (state_q[rd_idx_q] == BANK_FULL) begin
            state_d[rd_idx_q] = BANK_SHOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i] <= BANK_FREE;
                id_q[i]    <= '0;
            end
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_sel_q     <= '0;
            rd_sel_q     <= '0;
            full_count_q <= '0;
            display_id_q <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            full_count_q <= full_count_d;
            display_id_q <= display_id_d;
        end
    end

`ifdef FRAMEBLOCK_AUTOCLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_busy_q <= 1'b0;
            clear_addr_q <= '0;
        end else begin
            clear_busy_q <= clear_busy_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    assign write_en    = (draw_we && draw_ready) || clear_busy_q;
    assign bank_wraddr = clear_busy_q ? clear_addr_q : draw_wraddr;
    assign bank_wrdata = clear_busy_q ? CLEAR_VALUE  : draw_wrdata;
`else
    assign write_en    = draw_we && draw_ready;
    assign bank_wraddr = draw_wraddr;
    assign bank_wrdata = draw_wrdata;
`endif

    for (genvar i = 0; i < NUM_BUF; i++) begin : g_bank
        assign bank_we[i]     = write_en && (wr_idx_q == IDX_W'(i));
        // A bank being drawn is read by the draw side; otherwise display owns the address.
        assign bank_rdaddr[i] = ((rd_idx_q == IDX_W'(i)) && (state_q[i] != BANK_DRAW))
                                ? display_rdaddr : draw_rdaddr;

        frameblock_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk    (clk),
            .we     (bank_we[i]),
            .wraddr (bank_wraddr),
            .wrdata (bank_wrdata),
            .rdaddr (bank_rdaddr[i]),
            .rddata (bank_rddata[i])
        );
    end

    assign draw_rddata    = bank_rddata[wr_sel_q];
    assign display_rddata = bank_rddata[rd_sel_q];
    assign display_id     = display_id_q;
    assign full_count     = full_count_q;

endmodule
